// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: access sizes, FSM states
// and the load lane-extraction helper.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    IDLE,
    LOAD
  } state_t;

  // Pick the addressed lane(s) out of a little-endian RAM word and extend.
  // Size 11 falls through to the full word.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [1:0]  size,
                                               input logic        sign_ext);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: r = {{24{sign_ext & b[7]}}, b};
      SZ_HALF: r = {{16{sign_ext & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_access_stage_data_ram.sv
// Single-port data RAM: registered read, per-byte write enables, no reset.
module data_ram #(
  parameter int    ADDR_W    = 10,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W] = '{default: '0};

  // Byte-lane writes and read-before-write registered read.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS memory-access stage: registered data RAM, sub-word loads/stores,
// misalignment faults and writeback select. Loads hold off upstream for one
// extra cycle while the RAM read completes.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int    ADDR_W    = 10,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [31:0] pc_plus_4,
  input  logic [31:0] next_pc_in,
  input  logic [1:0]  size,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        sign_ext,
  input  logic        jal,
  input  logic        sel,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [31:0] wb_next_pc,
  output logic        wb_fault
);

  state_t      state, state_nx;
  logic        accept, is_store, is_load, misaligned;
  logic [1:0]  off;
  logic [3:0]  we;
  logic [31:0] wdata, rdata;

  logic [1:0]  ld_size, ld_off;
  logic        ld_sext, ld_sel;
  logic [31:0] ld_pc;

  assign off        = alu_result[1:0];
  assign in_ready   = (state == IDLE);
  assign accept     = in_valid & in_ready;
  assign is_store   = mem_write;
  assign is_load    = mem_read & ~mem_write;
  assign misaligned = (is_store | is_load) &
                      (((size == SZ_HALF) & off[0]) | (size[1] & (off != 2'b00)));

  data_ram #(
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .addr  (alu_result[ADDR_W+1:2]),
    .wdata (wdata),
    .rdata (rdata)
  );

  // Next state plus store lane enables and replicated write data.
  always_comb begin
    state_nx = state;
    we       = '0;
    case (size)
      SZ_BYTE: wdata = {4{store_data[7:0]}};
      SZ_HALF: wdata = {2{store_data[15:0]}};
      default: wdata = store_data;
    endcase
    case (state)
      IDLE: begin
        if (accept && is_load && !misaligned) state_nx = LOAD;
        if (accept && is_store && !misaligned && sel && !rst) begin
          case (size)
            SZ_BYTE: we = 4'b0001 << off;
            SZ_HALF: we = off[1] ? 4'b1100 : 4'b0011;
            default: we = 4'b1111;
          endcase
        end
      end
      LOAD:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Capture load attributes at accept for use in the LOAD cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      ld_size <= size;
      ld_sext <= sign_ext;
      ld_off  <= off;
      ld_sel  <= sel;
      ld_pc   <= next_pc_in;
    end
  end

  // Writeback result registers; wb_valid pulses once per completing op.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid   <= 1'b0;
      wb_fault   <= 1'b0;
      wb_data    <= '0;
      wb_next_pc <= '0;
    end else begin
      wb_valid <= 1'b0;
      wb_fault <= 1'b0;
      if (state == LOAD) begin
        wb_valid   <= 1'b1;
        wb_data    <= ld_sel ? load_extract(rdata, ld_off, ld_size, ld_sext) : '0;
        wb_next_pc <= ld_pc;
      end else if (accept && !(is_load && !misaligned)) begin
        wb_valid   <= 1'b1;
        wb_next_pc <= next_pc_in;
        if (misaligned) begin
          wb_fault <= 1'b1;
          wb_data  <= '0;
        end else if (is_store) begin
          wb_data  <= alu_result;
        end else begin
          wb_data  <= jal ? pc_plus_4 : alu_result;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomised self-checking bench for mem_access_stage against a byte-array
// memory model.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] alu_result = '0, store_data = '0, pc_plus_4 = '0, next_pc_in = '0;
  logic [1:0]  size = '0;
  logic        mem_read = 1'b0, mem_write = 1'b0, sign_ext = 1'b0, jal = 1'b0, sel = 1'b0;
  logic        wb_valid, wb_fault;
  logic [31:0] wb_data, wb_next_pc;

  mem_access_stage #(.ADDR_W(10), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .store_data(store_data), .pc_plus_4(pc_plus_4),
    .next_pc_in(next_pc_in), .size(size), .mem_read(mem_read),
    .mem_write(mem_write), .sign_ext(sign_ext), .jal(jal), .sel(sel),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_next_pc(wb_next_pc),
    .wb_fault(wb_fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;
  logic [7:0] m [256];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] mload(input int a, input logic [1:0] sz, input logic sx);
    logic [31:0] v = '0;
    int n = nbytes(sz);
    for (int i = 0; i < n; i++) v |= 32'(m[a+i]) << (8*i);
    if (sx && n < 4 && v[8*n-1]) v |= 32'hFFFFFFFF << (8*n);
    return v;
  endfunction

  // Present one op, wait for its completion and compare with the model.
  task automatic do_op(input logic rd, input logic wr, input logic jl, input logic sx,
                       input logic sl, input logic [1:0] sz, input logic [31:0] alu,
                       input logic [31:0] sd, input logic [31:0] pc4, input logic [31:0] npc,
                       output logic [31:0] got);
    bit mis, ld;
    int a, n;
    logic [31:0] exp;
    a   = int'(alu[7:0]);
    n   = nbytes(sz);
    mis = (rd || wr) && (a % n != 0);
    ld  = rd && !wr && !mis;
    if (mis)      exp = '0;
    else if (wr) begin
      exp = alu;
      if (sl) for (int i = 0; i < n; i++) m[a+i] = sd[8*i +: 8];
    end
    else if (rd)  exp = sl ? mload(a, sz, sx) : '0;
    else          exp = jl ? pc4 : alu;

    in_valid = 1'b1; mem_read = rd; mem_write = wr; jal = jl; sign_ext = sx;
    sel = sl; size = sz; alu_result = alu; store_data = sd;
    pc_plus_4 = pc4; next_pc_in = npc;
    check("ready_at_issue", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (ld) begin
      check("load_wait_valid", 32'(wb_valid), 32'd0);
      check("load_wait_ready", 32'(in_ready), 32'd0);
      // A store presented while not ready must be ignored.
      in_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1; size = 2'd2; sel = 1'b1;
      alu_result = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      store_data = $urandom;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("load_done_ready", 32'(in_ready), 32'd1);
    end
    check("wb_valid", 32'(wb_valid), 32'd1);
    check("wb_data", wb_data, exp);
    check("wb_fault", 32'(wb_fault), 32'(mis));
    check("wb_next_pc", wb_next_pc, npc);
    got = wb_data;
  endtask

  initial begin
    logic [31:0] got;
    int c0, kind;
    for (int i = 0; i < 256; i++) m[i] = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(wb_valid), 32'd0);
    check("rst_fault", 32'(wb_fault), 32'd0);
    check("rst_data", wb_data, 32'd0);
    check("rst_npc", wb_next_pc, 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    // Bring the tested region to a known state.
    for (int i = 0; i < 64; i++)
      do_op(0, 1, 0, 0, 1, 2'd2, 32'(4*i), 32'd0, 32'd0, 32'(i), got);

    // Byte load with and without sign extension.
    do_op(0, 1, 0, 0, 1, 2'd2, 32'h10, 32'h8899AABB, 0, 32'h100, got);
    do_op(1, 0, 0, 1, 1, 2'd0, 32'h13, 0, 0, 32'h104, got);
    check("lb_sext", got, 32'hFFFFFF88);
    do_op(1, 0, 0, 0, 1, 2'd0, 32'h13, 0, 0, 32'h108, got);
    check("lb_zext", got, 32'h00000088);

    // Half store merged into an existing word.
    do_op(0, 1, 0, 0, 1, 2'd2, 32'h20, 32'hDEADBEEF, 0, 32'h10C, got);
    do_op(0, 1, 0, 0, 1, 2'd1, 32'h22, 32'h00001234, 0, 32'h110, got);
    do_op(1, 0, 0, 0, 1, 2'd2, 32'h20, 0, 0, 32'h114, got);
    check("sh_merge", got, 32'h1234BEEF);

    // Link value for jal.
    do_op(0, 0, 1, 0, 1, 2'd0, 32'h1234, 0, 32'h00400008, 32'h0040000C, got);
    check("jal_link", got, 32'h00400008);

    // Misaligned word store leaves memory untouched.
    do_op(0, 1, 0, 0, 1, 2'd2, 32'h06, 32'h55555555, 0, 32'h118, got);
    do_op(1, 0, 0, 0, 1, 2'd2, 32'h04, 0, 0, 32'h11C, got);
    check("mis_untouched", got, 32'h00000000);

    // Chip select low: load reads zero, store is dropped.
    do_op(1, 0, 0, 0, 0, 2'd2, 32'h10, 0, 0, 32'h120, got);
    check("sel0_load", got, 32'd0);
    do_op(0, 1, 0, 0, 0, 2'd2, 32'h10, 32'h11111111, 0, 32'h124, got);
    do_op(1, 0, 0, 0, 1, 2'd2, 32'h10, 0, 0, 32'h128, got);
    check("sel0_store", got, 32'h8899AABB);

    // Reset coincident with a store accept suppresses the write.
    in_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1; size = 2'd2; sel = 1'b1;
    alu_result = 32'h30; store_data = 32'hCAFEF00D; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    check("rst_store_valid", 32'(wb_valid), 32'd0);
    do_op(1, 0, 0, 0, 1, 2'd2, 32'h30, 0, 0, 32'h12C, got);

    // Reset during the LOAD cycle drops the pending load.
    in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; size = 2'd2; sel = 1'b1;
    alu_result = 32'h10;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rstld_busy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstld_valid", 32'(wb_valid), 32'd0);
    check("rstld_ready", 32'(in_ready), 32'd1);

    // Back-to-back ALU ops complete one per cycle.
    c0 = cyc;
    for (int i = 0; i < 4; i++)
      do_op(0, 0, 1'($urandom), 0, 1, 2'd0, $urandom, 0, $urandom, $urandom, got);
    check("b2b_cycles", 32'(cyc - c0), 32'd4);

    // Randomised mix of loads, stores and ALU ops.
    for (int t = 0; t < 400; t++) begin
      kind = int'($urandom_range(0, 3));
      case (kind)
        0, 3: do_op(kind == 3, 1, 0, 0, ($urandom % 8) != 0, 2'($urandom),
                    32'($urandom_range(0, 255)), $urandom, $urandom, $urandom, got);
        1:    do_op(1, 0, 0, 1'($urandom), ($urandom % 8) != 0, 2'($urandom),
                    32'($urandom_range(0, 255)), $urandom, $urandom, $urandom, got);
        default: do_op(0, 0, 1'($urandom), 0, 1, 2'd0, $urandom, $urandom,
                       $urandom, $urandom, got);
      endcase
      if ($urandom % 5 == 0) begin
        @(posedge clk); #1;
        check("idle_no_valid", 32'(wb_valid), 32'd0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
